// File: rtl/dcache_wb_dm.sv
// dcache_wb_dm: direct-mapped, write-back, write-allocate data cache that sits
// between the MEM stage and the data-memory block interface.
//
// State | Meaning
// ------+---------------------------------------------------------------
// IDLE  | serve hits; flush or miss starts a transfer sequence
// EVICT | write the dirty victim line back (dBlkWrite held until ack)
// FILL  | read the requested line (dBlkRead held until ack)
// FL_SCAN  | flush: inspect one line per cycle, invalidate clean lines
// FL_EVICT | flush: write back the dirty line at the scan index
// FL_DONE  | flush complete; flush_done high until flush_2DC drops
//
// Ports:
//   CLK, RESET             clock (rising edge), synchronous active-high reset
//   data_address_2DC       byte address from MEM
//   read_2DC / write_2DC   word read / 1-4 byte write request
//   data_write_2DC         right-justified write data
//   data_write_size_2DC    bytes to write (0 means 4)
//   flush_2DC              flush request, held until flush_done
//   data_read_fDC          addressed word (pre-write value on writes)
//   data_valid_fDC         request completes this cycle (combinational on hit)
//   flush_done             every line clean and invalid
//   mem_block_address      line-aligned address of the fill/evict
//   dBlkRead / dBlkWrite   block read / write requests
//   block_read_fDM(_valid) fill data and its acknowledge
//   block_write_2DM        line being evicted
//   block_write_fDM_valid  evict acknowledge

module dcache_wb_dm #(
    parameter int INDEX_BITS = 5,
    parameter int BLOCK_BITS = 256
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [31:0]           data_address_2DC,
    input  logic                  read_2DC,
    input  logic                  write_2DC,
    input  logic [31:0]           data_write_2DC,
    input  logic [1:0]            data_write_size_2DC,
    input  logic                  flush_2DC,
    output logic [31:0]           data_read_fDC,
    output logic                  data_valid_fDC,
    output logic                  flush_done,
    output logic [31:0]           mem_block_address,
    output logic                  dBlkRead,
    output logic                  dBlkWrite,
    input  logic [BLOCK_BITS-1:0] block_read_fDM,
    input  logic                  block_read_fDM_valid,
    output logic [BLOCK_BITS-1:0] block_write_2DM,
    input  logic                  block_write_fDM_valid
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 27 - INDEX_BITS;

    generate
        if (BLOCK_BITS != 256) begin : gBlockBitsCheck
            $error("dcache_wb_dm supports only 256-bit lines");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE, EVICT, FILL, FL_SCAN, FL_EVICT, FL_DONE
    } cacheState_e;

    cacheState_e state, nextState;

    logic                  validArr [LINES];
    logic                  dirtyArr [LINES];
    logic [TAG_BITS-1:0]   tagArr   [LINES];
    logic [BLOCK_BITS-1:0] dataArr  [LINES];

    logic [INDEX_BITS-1:0] scanIdx;

    logic [TAG_BITS-1:0]   reqTag;
    logic [INDEX_BITS-1:0] reqIndex;
    logic [2:0]            reqWord;
    logic [1:0]            reqByte;
    logic                  reqActive;
    logic                  hit;
    logic                  writeHit;
    logic                  scanDirty;
    logic [31:0]           curWord;
    logic [31:0]           mergedWord;

    // Writes land MSB first starting at byte offset b (big-endian within the
    // word); bytes that would spill past offset 3 are discarded.
    function automatic logic [31:0] mergeBytes(input logic [31:0] oldWord,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  size,
                                               input logic [1:0]  b);
        logic [31:0] w;
        int n;
        int off;
        int src;
        w = oldWord;
        n = (size == 2'd0) ? 4 : int'(size);
        for (int k = 0; k < 4; k++) begin
            off = int'(b) + k;
            if (k < n && off < 4) begin
                src = 8 * (n - 1 - k);
                w[8*(3-off) +: 8] = wdata[src +: 8];
            end
        end
        return w;
    endfunction

    assign reqTag     = data_address_2DC[31 -: TAG_BITS];
    assign reqIndex   = data_address_2DC[5+INDEX_BITS-1:5];
    assign reqWord    = data_address_2DC[4:2];
    assign reqByte    = data_address_2DC[1:0];
    assign reqActive  = read_2DC | write_2DC;
    assign hit        = validArr[reqIndex] && (tagArr[reqIndex] == reqTag);
    assign writeHit   = (state == IDLE) && !flush_2DC && write_2DC && hit;
    assign scanDirty  = validArr[scanIdx] && dirtyArr[scanIdx];
    assign curWord    = dataArr[reqIndex][{reqWord, 5'b0} +: 32];
    assign mergedWord = mergeBytes(curWord, data_write_2DC, data_write_size_2DC, reqByte);

    assign data_read_fDC = curWord;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= IDLE;
            scanIdx <= '0;
        end else begin
            state <= nextState;
            if (state == IDLE)
                scanIdx <= '0;
            else if (state == FL_SCAN && !scanDirty && scanIdx != '1)
                scanIdx <= scanIdx + 1'b1;
        end
    end

    always_comb begin
        nextState         = state;
        data_valid_fDC    = 1'b0;
        flush_done        = 1'b0;
        dBlkRead          = 1'b0;
        dBlkWrite         = 1'b0;
        mem_block_address = '0;
        block_write_2DM   = '0;
        case (state)
            IDLE: begin
                if (flush_2DC)
                    nextState = FL_SCAN;
                else if (reqActive) begin
                    if (hit)
                        data_valid_fDC = 1'b1;
                    else if (validArr[reqIndex] && dirtyArr[reqIndex])
                        nextState = EVICT;
                    else
                        nextState = FILL;
                end
            end
            EVICT: begin
                dBlkWrite         = 1'b1;
                mem_block_address = {tagArr[reqIndex], reqIndex, 5'b0};
                block_write_2DM   = dataArr[reqIndex];
                if (block_write_fDM_valid)
                    nextState = FILL;
            end
            FILL: begin
                dBlkRead          = 1'b1;
                mem_block_address = {reqTag, reqIndex, 5'b0};
                if (block_read_fDM_valid)
                    nextState = IDLE;
            end
            FL_SCAN: begin
                if (scanDirty)
                    nextState = FL_EVICT;
                else if (scanIdx == '1)
                    nextState = FL_DONE;
            end
            FL_EVICT: begin
                dBlkWrite         = 1'b1;
                mem_block_address = {tagArr[scanIdx], scanIdx, 5'b0};
                block_write_2DM   = dataArr[scanIdx];
                // Line stays valid so the following scan cycle invalidates it.
                if (block_write_fDM_valid)
                    nextState = FL_SCAN;
            end
            FL_DONE: begin
                flush_done = flush_2DC;
                if (!flush_2DC)
                    nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
        // Request lines are registered by state and drop the cycle after
        // reset; completion flags are suppressed immediately.
        if (RESET) begin
            data_valid_fDC = 1'b0;
            flush_done     = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < LINES; i++) begin
                validArr[i] <= 1'b0;
                dirtyArr[i] <= 1'b0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (writeHit)
                        dirtyArr[reqIndex] <= 1'b1;
                end
                EVICT: begin
                    if (block_write_fDM_valid)
                        dirtyArr[reqIndex] <= 1'b0;
                end
                FILL: begin
                    if (block_read_fDM_valid) begin
                        validArr[reqIndex] <= 1'b1;
                        dirtyArr[reqIndex] <= 1'b0;
                    end
                end
                FL_SCAN: begin
                    if (!scanDirty)
                        validArr[scanIdx] <= 1'b0;
                end
                FL_EVICT: begin
                    if (block_write_fDM_valid)
                        dirtyArr[scanIdx] <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Tag and data storage need no reset; validArr guards their use.
    always_ff @(posedge CLK) begin
        if (writeHit && !RESET)
            dataArr[reqIndex][{reqWord, 5'b0} +: 32] <= mergedWord;
        else if (state == FILL && block_read_fDM_valid && !RESET) begin
            dataArr[reqIndex] <= block_read_fDM;
            tagArr[reqIndex]  <= reqTag;
        end
    end

endmodule
